mdu_iter: RTL and testbench

- Iterative multiply/divide unit that services the EXE stage's HI/LO instructions: MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- It is the responder side of the EXE hilo interface. EXE issues an op with rs/rt operands; the unit computes over multiple cycles and owns the HI/LO architectural registers.
- It drives a stall request back to the hazard logic while a result is pending.

---
 rtl/mdu_iter_if.sv | 29 ++
 rtl/mdu_iter.sv | 174 +++++++++++++++++
 tb/tb_mdu_iter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// EXE <-> multiply/divide unit HI/LO interface. EXE is the master; mdu_iter is the slave.
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hilo_wd;
    logic             rd_hilo;
    logic             abort;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall_req;

    modport master (
        output start, op, rs_val, rt_val, hi_we, lo_we, hilo_wd, rd_hilo, abort,
        input  hi, lo, busy, done, stall_req
    );

    modport slave (
        input  start, op, rs_val, rt_val, hi_we, lo_we, hilo_wd, rd_hilo, abort,
        output hi, lo, busy, done, stall_req
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift-add/subtract step per cycle.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiply (divide stays iterative).
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input logic        i_clk,
    input logic        i_rst,
    mdu_iter_if.slave  io_hilo
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             r_state, w_state_nxt;
    logic [CntW-1:0]    r_cnt, w_cnt_nxt;
    logic               r_is_div, w_is_div_nxt;
    logic               r_neg_q, w_neg_q_nxt;
    logic               r_neg_r, w_neg_r_nxt;
    logic               r_div0, w_div0_nxt;
    logic [WIDTH-1:0]   r_dvsr, w_dvsr_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_hi, w_hi_nxt;
    logic [WIDTH-1:0]   r_lo, w_lo_nxt;
    logic               r_done, w_done_nxt;

    logic               w_busy;
    logic               w_accept;
    logic               w_rs_neg, w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag, w_rt_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_step;
    logic [2*WIDTH-1:0] w_div_step;
    logic [WIDTH-1:0]   w_rem, w_quo;
    logic [WIDTH-1:0]   w_rem_neg, w_quo_neg;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic               w_fast_mul;
    logic [2*WIDTH-1:0] w_fast_prod;

    assign w_busy   = (r_state != StIdle);
    assign w_accept = (r_state == StIdle) & io_hilo.start & ~io_hilo.abort;

    // Signed ops work on magnitudes; signs are re-applied in StFix.
    assign w_rs_neg = io_hilo.op[0] & io_hilo.rs_val[WIDTH-1];
    assign w_rt_neg = io_hilo.op[0] & io_hilo.rt_val[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? -io_hilo.rs_val : io_hilo.rs_val;
    assign w_rt_mag = w_rt_neg ? -io_hilo.rt_val : io_hilo.rt_val;

`ifdef MDU_FAST_MUL_EN
    assign w_fast_mul  = ~io_hilo.op[1];
    assign w_fast_prod = {{WIDTH{w_rs_neg}}, io_hilo.rs_val} * {{WIDTH{w_rt_neg}}, io_hilo.rt_val};
`else
    assign w_fast_mul  = 1'b0;
    assign w_fast_prod = '0;
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_dvsr} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = {1'b0, w_shift} - {2'b0, r_dvsr};
    assign w_qbit     = ~w_diff[WIDTH+1];
    assign w_rem_step = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_step = {w_rem_step, r_acc[WIDTH-2:0], w_qbit};

    // With a zero divisor the remainder ends up equal to |rs|, so the sign fix restores raw rs.
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo      = r_acc[WIDTH-1:0];
    assign w_rem_neg  = -w_rem;
    assign w_quo_neg  = -w_quo;
    assign w_prod_neg = -r_acc;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_div_nxt = r_is_div;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_div0_nxt   = r_div0;
        w_dvsr_nxt   = r_dvsr;
        w_acc_nxt    = r_acc;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_done_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_accept && w_fast_mul) begin
                    {w_hi_nxt, w_lo_nxt} = w_fast_prod;
                    w_done_nxt           = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt  = StRun;
                    w_cnt_nxt    = '0;
                    w_is_div_nxt = io_hilo.op[1];
                    w_neg_q_nxt  = w_rs_neg ^ w_rt_neg;
                    w_neg_r_nxt  = w_rs_neg;
                    w_div0_nxt   = io_hilo.op[1] & (io_hilo.rt_val == '0);
                    if (io_hilo.op[1]) begin
                        w_dvsr_nxt = w_rt_mag;
                        w_acc_nxt  = {{WIDTH{1'b0}}, w_rs_mag};
                    end else begin
                        w_dvsr_nxt = w_rs_mag;
                        w_acc_nxt  = {{WIDTH{1'b0}}, w_rt_mag};
                    end
                end else if (!io_hilo.start) begin
                    if (io_hilo.hi_we) w_hi_nxt = io_hilo.hilo_wd;
                    if (io_hilo.lo_we) w_lo_nxt = io_hilo.hilo_wd;
                end
            end
            StRun: begin
                if (io_hilo.abort) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_acc_nxt = r_is_div ? w_div_step : w_mul_step;
                    w_cnt_nxt = r_cnt + CntW'(1);
                    if (r_cnt == CntW'(WIDTH - 1)) w_state_nxt = StFix;
                end
            end
            StFix: begin
                w_state_nxt = StIdle;
                if (!io_hilo.abort) begin
                    w_done_nxt = 1'b1;
                    if (r_is_div) begin
                        w_lo_nxt = r_div0 ? '1 : (r_neg_q ? w_quo_neg : w_quo);
                        w_hi_nxt = r_neg_r ? w_rem_neg : w_rem;
                    end else begin
                        {w_hi_nxt, w_lo_nxt} = r_neg_q ? w_prod_neg : r_acc;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_dvsr   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_div0   <= w_div0_nxt;
            r_dvsr   <= w_dvsr_nxt;
            r_acc    <= w_acc_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign io_hilo.hi        = r_hi;
    assign io_hilo.lo        = r_lo;
    assign io_hilo.busy      = w_busy;
    assign io_hilo.done      = r_done;
    assign io_hilo.stall_req = w_busy & (io_hilo.start | io_hilo.rd_hilo |
                                         io_hilo.hi_we | io_hilo.lo_we);
endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter; expected values are hand-computed.
module tb_mdu_iter;
`ifdef MDU_FAST_MUL_EN
    localparam int MulLat = 0;
    localparam logic [1:0] AbortOp = 2'd2;
`else
    localparam int MulLat = 33;
    localparam logic [1:0] AbortOp = 2'd0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   lat;
    int   bcnt;
    int   extra;
    int   stall_bad;

    mdu_iter_if #(.WIDTH(32)) hilo_bus ();

    mdu_iter #(.WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .io_hilo (hilo_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        hilo_bus.start  = 1'b1;
        hilo_bus.op     = op;
        hilo_bus.rs_val = rs;
        hilo_bus.rt_val = rt;
        step();
        hilo_bus.start  = 1'b0;
    endtask

    // Edges from the start edge until done is seen; also counts busy cycles.
    task automatic wait_done(output int n, output int b);
        n = 0;
        b = 0;
        while (hilo_bus.done !== 1'b1 && n < 100) begin
            if (hilo_bus.busy === 1'b1) b++;
            step();
            n++;
        end
        chk("done_timeout", 64'(n < 100), 64'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        hilo_bus.start   = 1'b0;
        hilo_bus.op      = 2'd0;
        hilo_bus.rs_val  = '0;
        hilo_bus.rt_val  = '0;
        hilo_bus.hi_we   = 1'b0;
        hilo_bus.lo_we   = 1'b0;
        hilo_bus.hilo_wd = '0;
        hilo_bus.rd_hilo = 1'b0;
        hilo_bus.abort   = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_hi", 64'(hilo_bus.hi), 64'h0);
        chk("rst_lo", 64'(hilo_bus.lo), 64'h0);
        chk("rst_busy", 64'(hilo_bus.busy), 64'h0);
        chk("rst_done", 64'(hilo_bus.done), 64'h0);
        chk("rst_stall", 64'(hilo_bus.stall_req), 64'h0);

        // MULTU all-ones squared
        start_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        chk("multu_lat", 64'(lat), 64'(MulLat));
        chk("multu_busy_cycles", 64'(bcnt), 64'(MulLat));
        chk("multu_hi", 64'(hilo_bus.hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(hilo_bus.lo), 64'h0000_0001);
        chk("multu_done_busy", 64'(hilo_bus.busy), 64'h0);

        // MULT -3*7, started in the previous op's done cycle
        start_op(2'd1, 32'hFFFF_FFFD, 32'd7);
        chk("b2b_busy", 64'(hilo_bus.busy), (MulLat != 0) ? 64'h1 : 64'h0);
        wait_done(lat, bcnt);
        chk("mult_lat", 64'(lat), 64'(MulLat));
        chk("mult_hi", 64'(hilo_bus.hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(hilo_bus.lo), 64'hFFFF_FFEB);
        step();
        chk("done_one_cycle", 64'(hilo_bus.done), 64'h0);

        // DIV -7/2
        start_op(2'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt);
        chk("div_lat", 64'(lat), 64'd33);
        chk("div_busy_cycles", 64'(bcnt), 64'd33);
        chk("div_lo", 64'(hilo_bus.lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hilo_bus.hi), 64'hFFFF_FFFF);

        // DIVU by zero
        start_op(2'd2, 32'd7, 32'd0);
        wait_done(lat, bcnt);
        chk("divu0_lat", 64'(lat), 64'd33);
        chk("divu0_lo", 64'(hilo_bus.lo), 64'hFFFF_FFFF);
        chk("divu0_hi", 64'(hilo_bus.hi), 64'h0000_0007);

        // Signed DIV by zero keeps the raw negative dividend in hi
        start_op(2'd3, 32'hFFFF_FFF9, 32'd0);
        wait_done(lat, bcnt);
        chk("div0_lo", 64'(hilo_bus.lo), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(hilo_bus.hi), 64'hFFFF_FFF9);

        // DIV overflow case
        start_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        chk("divov_lo", 64'(hilo_bus.lo), 64'h8000_0000);
        chk("divov_hi", 64'(hilo_bus.hi), 64'h0);

        // DIVU 100/7 with MFHI pending and a second start while busy
        step();
        start_op(2'd2, 32'd100, 32'd7);
        step();
        hilo_bus.rd_hilo = 1'b1;
        step();
        chk("stall_rd", 64'(hilo_bus.stall_req), 64'h1);
        step();
        step();
        hilo_bus.start  = 1'b1;
        hilo_bus.op     = 2'd0;
        hilo_bus.rs_val = 32'd3;
        hilo_bus.rt_val = 32'd3;
        chk("stall_start", 64'(hilo_bus.stall_req), 64'h1);
        step();
        hilo_bus.start = 1'b0;
        lat       = 5;
        stall_bad = 0;
        while (hilo_bus.done !== 1'b1 && lat < 100) begin
            if (hilo_bus.busy !== 1'b1 || hilo_bus.stall_req !== 1'b1) stall_bad++;
            step();
            lat++;
        end
        chk("divu_stall_held", 64'(stall_bad), 64'd0);
        chk("divu_lat", 64'(lat), 64'd33);
        chk("divu_stall_done", 64'(hilo_bus.stall_req), 64'h0);
        chk("divu_lo", 64'(hilo_bus.lo), 64'd14);
        chk("divu_hi", 64'(hilo_bus.hi), 64'd2);
        hilo_bus.rd_hilo = 1'b0;
        step();
        chk("ignored_start_busy", 64'(hilo_bus.busy), 64'h0);
        chk("ignored_start_lo", 64'(hilo_bus.lo), 64'd14);

        // MTHI / MTLO then abort mid-op
        hilo_bus.hi_we   = 1'b1;
        hilo_bus.hilo_wd = 32'h11;
        step();
        hilo_bus.hi_we   = 1'b0;
        hilo_bus.lo_we   = 1'b1;
        hilo_bus.hilo_wd = 32'h22;
        step();
        hilo_bus.lo_we   = 1'b0;
        chk("mthi", 64'(hilo_bus.hi), 64'h11);
        chk("mtlo", 64'(hilo_bus.lo), 64'h22);
        start_op(AbortOp, 32'd5, 32'd6);
        for (int i = 0; i < 9; i++) step();
        hilo_bus.abort = 1'b1;
        step();
        hilo_bus.abort = 1'b0;
        chk("abort_busy", 64'(hilo_bus.busy), 64'h0);
        chk("abort_hi", 64'(hilo_bus.hi), 64'h11);
        chk("abort_lo", 64'(hilo_bus.lo), 64'h22);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (hilo_bus.done === 1'b1) extra++;
            step();
        end
        chk("abort_no_done", 64'(extra), 64'd0);

        // Reset in the middle of an op
        start_op(AbortOp, 32'd5, 32'd6);
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_hi", 64'(hilo_bus.hi), 64'h0);
        chk("midrst_lo", 64'(hilo_bus.lo), 64'h0);
        chk("midrst_busy", 64'(hilo_bus.busy), 64'h0);
        chk("midrst_done", 64'(hilo_bus.done), 64'h0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (hilo_bus.done === 1'b1 || hilo_bus.busy === 1'b1) extra++;
            step();
        end
        chk("midrst_quiet", 64'(extra), 64'd0);

        // start beats a simultaneous MTHI
        hilo_bus.hi_we   = 1'b1;
        hilo_bus.hilo_wd = 32'hAA;
        start_op(2'd0, 32'd2, 32'd3);
        hilo_bus.hi_we   = 1'b0;
        wait_done(lat, bcnt);
        chk("prio_lat", 64'(lat), 64'(MulLat));
        chk("prio_busy_cycles", 64'(bcnt), 64'(MulLat));
        chk("prio_hi", 64'(hilo_bus.hi), 64'h0);
        chk("prio_lo", 64'(hilo_bus.lo), 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
